alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//   Execute-to-writeback stage directly downstream of the ALU. Captures ALU result, flags and
//   destination info, buffers them in a small FIFO under valid/ready handshake, and owns the
//   architectural CZNV status register. Drives register-file writeback and illegal-op reporting.
// PARAMETERS
//   DATA_W  32  datapath width (result, writeback data)
//   RD_W    5   destination register index width
//   DEPTH   2   buffer entries; power of two, >= 2
// PORTS
//   clk          in   1       system clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   flush        in   1       synchronous pipeline flush
//   in_valid     in   1       upstream ALU op valid
//   in_ready     out  1       stage can accept this cycle
//   in_opcode    in   6       ALU opcode of the op
//   in_result    in   DATA_W  ALU result
//   in_carry     in   1       ALU carry
//   in_zero      in   1       ALU zero
//   in_negative  in   1       ALU negative
//   in_overflow  in   1       ALU overflow
//   in_rd        in   RD_W    destination register
//   in_wr_en     in   1       op writes a register
//   out_valid    out  1       writeback entry valid
//   out_ready    in   1       register file consumes entry
//   out_data     out  DATA_W  writeback data
//   out_rd       out  RD_W    writeback register
//   out_wr_en    out  1       writeback enable (qualified by out_valid)
//   flags        out  4       status register {C,Z,N,V}
//   illegal_op   out  1       one-cycle pulse: illegal opcode accepted
// BEHAVIOUR
//   - Reset (rst_n low, async): buffer empty, flags=0, out_*=0, illegal_op=0, in_ready=1.
//   - Accept = in_valid & in_ready; pop = out_valid & out_ready. in_ready = (count != DEPTH),
//     independent of out_ready. Full: no accept even if pop occurs in the same cycle.
//   - Latency: accepted op appears at out_* on the next cycle, at the earliest. FIFO order is preserved.
//   - Push & pop in the same cycle with 0 < count < DEPTH: count unchanged, pointers both advance
//     and wrap mod DEPTH.
//   - Legal opcodes: 0 AND, 1 ADD, 2 SUB, 3 OR, 4 ANDI, 5 ADDI.
//   - Flag update on accept (visible next cycle): legal ops load Z,N. Ops 1/2/5 also load C,V.
//     Ops 0/3/4 hold C,V.
//   - Illegal opcode (6..63) accepted: entry is stored with wr_en=0. Flags are held.
//     illegal_op=1 for exactly the following cycle.
//   - Stored wr_en = in_wr_en & legal & (in_rd != 0); r0 is never written.
//   - out_data/out_rd/out_wr_en reflect the head entry. They are 0 when empty and stable while
//     out_valid & ~out_ready.
//   - flush: on the next edge count=0 and pointers=0. An op presented in the flush cycle is dropped,
//     does not update flags and does not pulse illegal_op. Flags otherwise retain their value.
//     flush has priority over accept and pop.
//   - Async reset mid-transfer discards all entries immediately; no partial writeback is issued.
// STRUCTURE
//   - Shared package exec_pkg: opcode localparams (OP_AND..OP_ADDI), flag bit indices (FLG_C/Z/N/V),
//     entry struct {data, rd, wr_en}.
//   - One sub-module, sync_fifo (width = DATA_W+RD_W+1, depth DEPTH, with flush).
//     Flag register and illegal-op decode live in the top module.
// TESTING
//   - Reset: hold rst_n=0 -> out_valid=0, flags=4'b0000, in_ready=1, illegal_op=0.
//   - ADD, result 0x0000_0000, carry=1, zero=1, rd=3, out_ready=1
//     -> next cycle out_valid=1, out_data=0, out_rd=3, flags=4'b1100.
//   - Backpressure: out_ready=0, push 3 ops -> in_ready=0 after 2 accepts, third held.
//     out_ready=1 -> drained in order.
//   - OR after SUB with overflow (flags 4'b0001), OR result 0x8000_0000
//     -> flags=4'b0011 (V held, N set, Z clear).
//   - Opcode 6'd9, wr_en=1, rd=4 -> illegal_op pulse, out_wr_en=0, flags unchanged.
//     ADDI with rd=0 -> out_wr_en=0.
//   - Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     flags unchanged.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: ALU opcodes, status flag bit positions, writeback entry layout.
// The entry layout follows the default datapath widths.
package exec_pkg;

  localparam int EXEC_DATA_W = 32;
  localparam int EXEC_RD_W   = 5;

  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_ANDI = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    logic [EXEC_DATA_W-1:0] data;
    logic [EXEC_RD_W-1:0]   rd;
    logic                   wr_en;
  } entry_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op <= OP_ADDI;
  endfunction

  // Only the arithmetic ops produce meaningful carry/overflow.
  function automatic logic loads_cv(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head appears one cycle after push, reads zero when empty.
// Push is ignored when full and pop when empty; flush clears on the next edge and wins over both.
module sync_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer and CZNV status register; accepted op reaches writeback after >= 1 cycle.
// in_ready drops only when the buffer is full, regardless of out_ready; flush drops the in-flight op.
module alu_result_stage
  import exec_pkg::*;
#(
  parameter int DATA_W = EXEC_DATA_W,
  parameter int RD_W   = EXEC_RD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wr_en,
  output logic [3:0]        flags,
  output logic              illegal_op
);

  logic   w_legal;
  logic   w_accept;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  entry_t w_in_entry;
  entry_t w_head;
  logic [3:0] r_flags;
  logic       r_illegal;

  assign w_legal  = is_legal(in_opcode);
  assign in_ready = ~w_full;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_pop    = out_valid & out_ready;

  // r0 is hardwired zero, so writes to it are suppressed at capture time.
  assign w_in_entry.data  = in_result;
  assign w_in_entry.rd    = in_rd;
  assign w_in_entry.wr_en = in_wr_en & w_legal & (in_rd != '0);

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_accept),
    .i_din   (w_in_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid  = ~w_empty;
  assign out_data   = w_head.data;
  assign out_rd     = w_head.rd;
  assign out_wr_en  = w_head.wr_en;
  assign flags      = r_flags;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept && w_legal) begin
        r_flags[FLG_Z] <= in_zero;
        r_flags[FLG_N] <= in_negative;
        if (loads_cv(in_opcode)) begin
          r_flags[FLG_C] <= in_carry;
          r_flags[FLG_V] <= in_overflow;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: vector table for single ops, hand sequences for
// backpressure, flush and asynchronous reset.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_result;
  logic        in_carry, in_zero, in_negative, in_overflow;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  flags;
  logic        illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  alu_result_stage #(.DATA_W(32), .RD_W(5), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_zero     (in_zero),
    .in_negative (in_negative),
    .in_overflow (in_overflow),
    .in_rd       (in_rd),
    .in_wr_en    (in_wr_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_wr_en   (out_wr_en),
    .flags       (flags),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // cznv packs the ALU flags as {C,Z,N,V}.
  task automatic drive(input logic [5:0] op, input logic [31:0] res, input logic [3:0] cznv,
                       input logic [4:0] rd, input logic we);
    in_valid    = 1'b1;
    in_opcode   = op;
    in_result   = res;
    in_carry    = cznv[3];
    in_zero     = cznv[2];
    in_negative = cznv[1];
    in_overflow = cznv[0];
    in_rd       = rd;
    in_wr_en    = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] res;
    logic [3:0]  cznv;
    logic [4:0]  rd;
    logic        we;
    logic        exp_we;
    logic [3:0]  exp_flags;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"add_zero",  6'd1, 32'h0000_0000, 4'b1100, 5'd3,  1'b1, 1'b1, 4'b1100, 1'b0};
    vecs[1] = '{"sub_ovf",   6'd2, 32'h7FFF_FFFF, 4'b0001, 5'd5,  1'b1, 1'b1, 4'b0001, 1'b0};
    vecs[2] = '{"or_neg",    6'd3, 32'h8000_0000, 4'b1010, 5'd6,  1'b1, 1'b1, 4'b0011, 1'b0};
    vecs[3] = '{"illegal9",  6'd9, 32'h0000_1234, 4'b1111, 5'd4,  1'b1, 1'b0, 4'b0011, 1'b1};
    vecs[4] = '{"addi_r0",   6'd5, 32'h0000_0055, 4'b1000, 5'd0,  1'b1, 1'b0, 4'b1000, 1'b0};
    vecs[5] = '{"and_hold",  6'd0, 32'h0000_0000, 4'b0101, 5'd7,  1'b1, 1'b1, 4'b1100, 1'b0};
    vecs[6] = '{"andi_neg",  6'd4, 32'hFFFF_0000, 4'b0011, 5'd31, 1'b1, 1'b1, 4'b1010, 1'b0};
    vecs[7] = '{"add_nowe",  6'd1, 32'h0000_0001, 4'b0000, 5'd2,  1'b0, 1'b0, 4'b0000, 1'b0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(6'd0, 32'h0, 4'b0000, 5'd0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].cznv, vecs[i].rd, vecs[i].we);
      chk({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk({vecs[i].name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({vecs[i].name, "_out_data"}, out_data, vecs[i].res);
      chk({vecs[i].name, "_out_rd"}, {27'b0, out_rd}, {27'b0, vecs[i].rd});
      chk({vecs[i].name, "_out_wr_en"}, {31'b0, out_wr_en}, {31'b0, vecs[i].exp_we});
      chk({vecs[i].name, "_flags"}, {28'b0, flags}, {28'b0, vecs[i].exp_flags});
      chk({vecs[i].name, "_illegal"}, {31'b0, illegal_op}, {31'b0, vecs[i].exp_ill});
      step();
      chk({vecs[i].name, "_drained"}, {31'b0, out_valid}, 32'd0);
      chk({vecs[i].name, "_ill_clear"}, {31'b0, illegal_op}, 32'd0);
    end

    // Backpressure: two fill the buffer, the third waits for a slot.
    out_ready = 1'b0;
    drive(6'd1, 32'hAAAA_0001, 4'b0000, 5'd1, 1'b1);
    step();
    drive(6'd1, 32'hBBBB_0002, 4'b0000, 5'd2, 1'b1);
    step();
    drive(6'd1, 32'hCCCC_0003, 4'b0000, 5'd3, 1'b1);
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_head_a", out_data, 32'hAAAA_0001);
    step();
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head_stable", out_data, 32'hAAAA_0001);
    chk("bp_head_rd", {27'b0, out_rd}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_head_b", out_data, 32'hBBBB_0002);
    chk("bp_ready_again", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", out_data, 32'hCCCC_0003);
    chk("bp_valid_c", {31'b0, out_valid}, 32'd1);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush with two entries buffered and a flag-changing op presented.
    out_ready = 1'b0;
    drive(6'd1, 32'h0000_0010, 4'b1000, 5'd8, 1'b1);
    step();
    drive(6'd1, 32'h0000_0011, 4'b1000, 5'd9, 1'b1);
    step();
    chk("fl_pre_flags", {28'b0, flags}, 32'b1000);
    drive(6'd2, 32'h0000_0000, 4'b0111, 5'd10, 1'b1);
    flush = 1'b1;
    step();
    chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_flags", {28'b0, flags}, 32'b1000);
    chk("fl_out_data", out_data, 32'd0);
    drive(6'd9, 32'h0000_0077, 4'b0000, 5'd4, 1'b1);
    step();
    chk("fl_no_illegal", {31'b0, illegal_op}, 32'd0);
    chk("fl_dropped", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    // Asynchronous reset with an entry pending.
    drive(6'd1, 32'hDEAD_BEEF, 4'b1111, 5'd12, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_pending", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_out_wr_en", {31'b0, out_wr_en}, 32'd0);
    chk("ar_flags", {28'b0, flags}, 32'd0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("ar_stays_empty", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
